// File: rtl/uart_time_reporter.sv
// Snapshots the selected 24-bit time on a report request and streams it as an ASCII line
// through the uart_tx start/busy/done handshake. Define REPORT_MSEC_EN to append ".CC".
module uart_time_reporter #(
    parameter logic [7:0] PREFIX_W = 8'h57,
    parameter logic [7:0] PREFIX_S = 8'h53
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_report,
    input  logic        i_sw_mode,
    input  logic [23:0] i_sw_time,
    input  logic [23:0] i_w_time,
    input  logic        i_tx_busy,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_frame_done
);

`ifdef REPORT_MSEC_EN
    localparam logic [3:0] LAST_IDX = 4'd14;
`else
    localparam logic [3:0] LAST_IDX = 4'd11;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

    state_t      state;
    logic        pending;
    logic [3:0]  index;
    logic        snap_mode;
    logic [23:0] snap_time;

    logic [23:0] sel_time;
    logic        src_mode;
    logic [23:0] src_time;
    logic [3:0]  src_idx;
    logic [6:0]  hr7, mn7, sc7;
    logic [7:0]  next_byte;

    function automatic logic [7:0] digit_hi(input logic [6:0] v);
        logic [6:0] q;
        q = v / 7'd10;
        return 8'h30 + {1'b0, q};
    endfunction

    function automatic logic [7:0] digit_lo(input logic [6:0] v);
        logic [6:0] r;
        r = v % 7'd10;
        return 8'h30 + {1'b0, r};
    endfunction

    assign sel_time = i_sw_mode ? i_sw_time : i_w_time;

    // The byte decoder looks one step ahead so each start can be registered without a bubble:
    // LOAD emits byte 0 straight from the inputs, WAIT emits the byte after the current index.
    always_comb begin
        src_mode = snap_mode;
        src_time = snap_time;
        src_idx  = index;
        if (state == LOAD) begin
            src_mode = i_sw_mode;
            src_time = sel_time;
            src_idx  = 4'd0;
        end else if (state == WAIT) begin
            src_idx  = index + 4'd1;
        end
    end

    assign hr7 = {2'b00, src_time[23:19]};
    assign mn7 = {1'b0, src_time[18:13]};
    assign sc7 = {1'b0, src_time[12:7]};

`ifdef REPORT_MSEC_EN
    logic [6:0] cs7;
    assign cs7 = (src_time[6:0] > 7'd99) ? 7'd99 : src_time[6:0];
`else
    logic unused_msec;
    assign unused_msec = &{1'b0, src_time[6:0]};
`endif

    always_comb begin
        next_byte = 8'h00;
        case (src_idx)
            4'd0:  next_byte = src_mode ? PREFIX_S : PREFIX_W;
            4'd1:  next_byte = 8'h20;
            4'd2:  next_byte = digit_hi(hr7);
            4'd3:  next_byte = digit_lo(hr7);
            4'd4:  next_byte = 8'h3A;
            4'd5:  next_byte = digit_hi(mn7);
            4'd6:  next_byte = digit_lo(mn7);
            4'd7:  next_byte = 8'h3A;
            4'd8:  next_byte = digit_hi(sc7);
            4'd9:  next_byte = digit_lo(sc7);
`ifdef REPORT_MSEC_EN
            4'd10: next_byte = 8'h2E;
            4'd11: next_byte = digit_hi(cs7);
            4'd12: next_byte = digit_lo(cs7);
            4'd13: next_byte = 8'h0D;
            4'd14: next_byte = 8'h0A;
`else
            4'd10: next_byte = 8'h0D;
            4'd11: next_byte = 8'h0A;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            index        <= 4'd0;
            snap_mode    <= 1'b0;
            snap_time    <= 24'd0;
            o_tx_start   <= 1'b0;
            o_tx_data    <= 8'h00;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_tx_start   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_report && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_report) begin
                        state  <= LOAD;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    snap_mode <= i_sw_mode;
                    snap_time <= sel_time;
                    index     <= 4'd0;
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= next_byte;
                        state      <= WAIT;
                    end else begin
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= next_byte;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_tx_done) begin
                        if (index == LAST_IDX) begin
                            o_frame_done <= 1'b1;
                            // A request arriving with the final done still queues a frame.
                            if (pending || i_report) begin
                                pending <= 1'b0;
                                state   <= LOAD;
                            end else begin
                                o_busy  <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            index <= index + 4'd1;
                            if (!i_tx_busy) begin
                                o_tx_start <= 1'b1;
                                o_tx_data  <= next_byte;
                            end else begin
                                state      <= SEND;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Randomised/directed bench for uart_time_reporter with a behavioural uart_tx and a text-level
// reference of the expected report line. Honours REPORT_MSEC_EN like the design.
module tb_uart_time_reporter;

    logic        clk;
    logic        rst;
    logic        i_report;
    logic        i_sw_mode;
    logic [23:0] i_sw_time;
    logic [23:0] i_w_time;
    logic        i_tx_busy;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_frame_done;

    uart_time_reporter dut (
        .clk          (clk),
        .rst          (rst),
        .i_report     (i_report),
        .i_sw_mode    (i_sw_mode),
        .i_sw_time    (i_sw_time),
        .i_w_time     (i_w_time),
        .i_tx_busy    (i_tx_busy),
        .i_tx_done    (i_tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rep_cyc;
    int busy_len;
    int tx_cnt;
    logic force_done;
    int fd_cnt;
    int fd_cyc;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int st_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural uart_tx: busy for busy_len cycles after each start, done pulses as busy drops.
    initial begin
        i_tx_busy = 1'b0;
        i_tx_done = 1'b0;
        tx_cnt = 0;
        fd_cnt = 0;
        fd_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            i_tx_done = force_done;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    i_tx_busy = 1'b0;
                    i_tx_done = 1'b1;
                end
            end
            if (o_tx_start) begin
                got_q.push_back(o_tx_data);
                st_q.push_back(cyc);
                i_tx_busy = 1'b1;
                tx_cnt = busy_len;
            end
            if (o_frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    // Reference line built from the time fields with plain decimal arithmetic.
    task automatic push_exp(input logic mode, input logic [23:0] t);
        int f[3];
        int cs;
        f[0] = int'(t[23:19]);
        f[1] = int'(t[18:13]);
        f[2] = int'(t[12:7]);
        exp_q.push_back(mode ? 8'h53 : 8'h57);
        exp_q.push_back(8'h20);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) exp_q.push_back(8'h3A);
            exp_q.push_back(8'(48 + f[i] / 10));
            exp_q.push_back(8'(48 + f[i] % 10));
        end
`ifdef REPORT_MSEC_EN
        cs = (int'(t[6:0]) > 99) ? 99 : int'(t[6:0]);
        exp_q.push_back(8'h2E);
        exp_q.push_back(8'(48 + cs / 10));
        exp_q.push_back(8'(48 + cs % 10));
`else
        cs = 0;
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic compare_bytes(input string tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
        st_q.delete();
    endtask

    task automatic send_report();
        @(negedge clk);
        i_report = 1'b1;
        rep_cyc = cyc;
        @(negedge clk);
        i_report = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((o_busy || i_tx_busy || tx_cnt != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk({tag, "_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("start_timeout", got_q.size(), n);
    endtask

    initial begin
        int fd0, n_at_rst;
        logic       m;
        logic [23:0] t, t_new;

        rst = 1'b1; i_report = 1'b0; i_sw_mode = 1'b0;
        i_sw_time = 24'd0; i_w_time = 24'd0; force_done = 1'b0; busy_len = 10;

        // Reset: 3 cycles with a stray done in the middle.
        @(negedge clk); force_done = 1'b1;
        @(negedge clk); force_done = 1'b0;
        @(negedge clk);
        chk("rst_start", o_tx_start, 0);
        chk("rst_data", o_tx_data, 8'h00);
        chk("rst_busy", o_busy, 0);
        chk("rst_fdone", o_frame_done, 0);
        rst = 1'b0;
        force_done = 1'b1;
        @(negedge clk); force_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_no_start", got_q.size(), 0);
        chk("idle_busy", o_busy, 0);

        // Watch frame 12:34:56.78.
        clear_q();
        fd0 = fd_cnt;
        i_w_time = {5'd12, 6'd34, 6'd56, 7'd78};
        i_sw_time = 24'hFFFFFF;
        push_exp(1'b0, i_w_time);
        send_report();
        chk("busy_after_req", o_busy, 1);
        wait_idle("watch", 400);
        compare_bytes("watch");
        chk("watch_frames", fd_cnt - fd0, 1);
        if (st_q.size() == exp_q.size()) begin
            chk("first_start_lat", st_q[0] - rep_cyc, 2);
            for (int i = 0; i + 1 < st_q.size(); i++)
                chk($sformatf("gap%0d", i), st_q[i+1] - st_q[i], busy_len + 1);
            chk("fdone_lat", fd_cyc - st_q[st_q.size()-1], busy_len + 1);
        end
        chk("watch_busy_end", o_busy, 0);

        // Stopwatch with centisecond clamp.
        clear_q();
        i_sw_mode = 1'b1;
        i_sw_time = {5'd0, 6'd5, 6'd9, 7'd120};
        push_exp(1'b1, i_sw_time);
        send_report();
        wait_idle("sw", 400);
        compare_bytes("sw");

        // Pending: three requests mid-frame, time and mode change mid-frame.
        clear_q();
        fd0 = fd_cnt;
        i_sw_mode = 1'b0;
        i_w_time = {5'd23, 6'd59, 6'd58, 7'd5};
        push_exp(1'b0, i_w_time);
        send_report();
        wait_starts(3, 200);
        t_new = {5'd31, 6'd63, 6'd0, 7'd99};
        i_sw_mode = 1'b1;
        i_sw_time = t_new;
        i_w_time = 24'd0;
        send_report();
        repeat (3) @(negedge clk);
        send_report();
        wait_starts(6, 200);
        send_report();
        push_exp(1'b1, t_new);
        wait_idle("pend", 1000);
        compare_bytes("pend");
        chk("pend_frames", fd_cnt - fd0, 2);

        // Reset after byte 6 started, then a clean frame.
        clear_q();
        i_sw_mode = 1'b0;
        i_w_time = {5'd7, 6'd8, 6'd9, 7'd10};
        send_report();
        wait_starts(7, 200);
        @(negedge clk);
        rst = 1'b1;
        n_at_rst = got_q.size();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_data", o_tx_data, 8'h00);
        repeat (40) @(negedge clk);
        chk("midrst_no_start", got_q.size(), n_at_rst);
        clear_q();
        push_exp(1'b0, i_w_time);
        send_report();
        wait_idle("postrst", 400);
        compare_bytes("postrst");

        // Random frames with varying transmitter speed.
        for (int r = 0; r < 8; r++) begin
            clear_q();
            fd0 = fd_cnt;
            busy_len = $urandom_range(1, 12);
            m = 1'($urandom_range(0, 1));
            i_sw_mode = m;
            i_sw_time = 24'($urandom);
            i_w_time = 24'($urandom);
            t = m ? i_sw_time : i_w_time;
            push_exp(m, t);
            send_report();
            wait_idle("rnd", 500);
            compare_bytes($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_frames", r), fd_cnt - fd0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_time_reporter.md
# uart_time_reporter

Transmit-side companion to the command receive path: on a report request it snapshots the currently selected 24-bit time value and serialises it as an ASCII line. The line goes out through the byte-level start/busy/done handshake of the existing UART transmitter, so a PC terminal sees what the FND shows. It sits between the mode manager / time datapaths and `uart_tx`, sharing the baud tick generator with the receive path.

## Interface
- `PREFIX_W`, 8'h57, ASCII prefix byte for watch mode ('W').
- `PREFIX_S`, 8'h53, ASCII prefix byte for stopwatch mode ('S').
- `clk`  in  1  system clock; only clock in the block.
- `rst`  in  1  reset: synchronous, active-high.
- `i_report`  in  1  one-cycle request pulse from the command decoder.
- `i_sw_mode`  in  1  1 = stopwatch, 0 = watch; selects time source and prefix.
- `i_sw_time`  in  24  stopwatch time {hour[23:19], min[18:13], sec[12:7], msec[6:0]}.
- `i_w_time`  in  24  watch time, same layout.
- `i_tx_busy`  in  1  transmitter busy level.
- `i_tx_done`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `o_tx_start`  out  1  one-cycle pulse; `o_tx_data` valid in the same cycle.
- `o_tx_data`  out  8  byte to send.
- `o_busy`  out  1  high from request acceptance to the end of the frame.
- `o_frame_done`  out  1  one-cycle pulse after the last byte's `i_tx_done`.

## Operation
- Frame, with `REPORT_MSEC_EN` defined: prefix, ' ', H, H, ':', M, M, ':', S, S, '.', C, C, CR, LF. Total 15 bytes.
- Each field is two ASCII decimal digits: tens = v/10, ones = v%10, then + 8'h30.
- hour range 0–31; min and sec range 0–63. All print as-is; no validity check.
- msec field is 7 bits and printed as centiseconds. Values above 99 clamp to "99".
- FSM states: IDLE, LOAD, SEND, WAIT.
  - IDLE: when `i_report`=1 go to LOAD and set `o_busy`.
  - LOAD: latch `i_sw_mode` and the selected time into a snapshot register. Clear byte index to 0. Go to SEND.
  - SEND: when `i_tx_busy`=0, pulse `o_tx_start` with byte[index] and go to WAIT. Otherwise hold in SEND.
  - WAIT: on `i_tx_done`:
    - If index is the last byte, pulse `o_frame_done`. Then go to LOAD if pending is set (clear pending), else go to IDLE and clear `o_busy`.
    - Otherwise increment index and go to SEND.
- Pending flag (one-deep): `i_report` in any state other than IDLE sets it. Further requests while it is already set are dropped.
- A pending frame takes a fresh snapshot in its own LOAD cycle.
- The snapshot is frozen for the whole frame; time and mode changes mid-frame do not corrupt the line.
- `i_tx_done` outside WAIT is ignored.

## Timing
- Reset values: `o_tx_start`=0, `o_tx_data`=8'h00, `o_busy`=0, `o_frame_done`=0. Also state=IDLE, pending=0, index=0.
- Request latency: `i_report` at cycle N gives LOAD at N+1. First `o_tx_start` at N+2 if `i_tx_busy`=0.
- Inter-byte latency: `i_tx_done` at cycle M gives the next `o_tx_start` at M+1 if `i_tx_busy`=0.
- `o_frame_done` is asserted in the cycle after the last `i_tx_done`.
- `o_tx_data` holds its value until the next `o_tx_start`.
- Reset mid-frame: everything returns to reset values on the next edge. No further starts are issued and the partial line is abandoned.
- `i_report` coincident with the final `i_tx_done` sets pending. The next frame then follows.

## Configuration
- `REPORT_MSEC_EN`
  - Defined: the 15-byte frame including ". C C".
  - Undefined: a 12-byte frame (prefix, ' ', HH:MM:SS, CR, LF). The msec input bits are unused and no clamp logic is built. The last-byte index becomes 11.

## Test plan
- Reset: hold `rst` for 3 cycles -> all outputs 0; `i_tx_done` pulses are ignored; no start is issued.
- Watch frame: `i_sw_mode`=0, watch time 12:34:56 msec 78, model uart_tx with 10-cycle busy. Pulse `i_report` -> bytes 57 20 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A. First start at request+2; one `o_frame_done`.
- Stopwatch and clamp: `i_sw_mode`=1, stopwatch time 0:05:09 msec 120 -> line "S 00:05:09.99\r\n".
- Pending: three `i_report` pulses during a frame, with time changed mid-frame -> exactly two frames. Frame 1 matches the old snapshot; frame 2 matches the new time.
- Reset mid-frame: assert `rst` after byte 6's start -> no further `o_tx_start`. A new `i_report` afterwards yields a complete 15-byte frame.
- Macro off: build without `REPORT_MSEC_EN`, send the watch-frame stimulus -> 12 bytes 57 20 31 32 3A 33 34 3A 35 36 0D 0A.
